// File: rtl/note_scheduler.sv
// note_scheduler
//   Gameplay sequencer for the two-player dance game. Spawns one arrow prompt
//   per beat from an 8-bit LFSR, opens a hit window after each spawn, judges
//   both players' debounced pads against the prompt and keeps per-player
//   hit scores.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high; clears all state
//   game_active  in   1 = run, 0 = freeze (pause / not started)
//   a_in, b_in   in   [3:0] debounced pads, one-hot: [0] up [1] down [2] left [3] right
//   note_dir     out  [3:0] one-hot direction of the current prompt, 0 when none
//   note_valid   out  hit window open
//   note_idx     out  [7:0] prompts spawned so far
//   a_hit/a_miss/b_hit/b_miss  out  single-cycle judgement pulses
//   a_score, b_score           out  [SCORE_W-1:0] saturating hit counts
//   song_done    out  all prompts finished (held until reset)
//   state_dbg    out  [1:0] FSM state: 0 IDLE, 1 SPAWN, 2 WAIT, 3 DONE
module note_scheduler #(
  parameter int         BEAT_CYCLES   = 25_000_000,
  parameter int         WINDOW_CYCLES = 5_000_000,
  parameter int         NUM_NOTES     = 32,
  parameter logic [7:0] SEED          = 8'h01,
  parameter int         SCORE_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game_active,
  input  logic [3:0]         a_in,
  input  logic [3:0]         b_in,
  output logic [3:0]         note_dir,
  output logic               note_valid,
  output logic [7:0]         note_idx,
  output logic               a_hit,
  output logic               a_miss,
  output logic               b_hit,
  output logic               b_miss,
  output logic [SCORE_W-1:0] a_score,
  output logic [SCORE_W-1:0] b_score,
  output logic               song_done,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(BEAT_CYCLES + 1);
  localparam logic [CW-1:0]      WIN_END   = CW'(WINDOW_CYCLES);
  localparam logic [CW-1:0]      BEAT_END  = CW'(BEAT_CYCLES - 2);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [7:0]         LAST_IDX  = 8'(NUM_NOTES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_WAIT, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_lfsr;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_note_dir;
  logic               r_note_valid;
  logic [7:0]         r_note_idx;
  logic [3:0]         r_a_prev, r_b_prev;
  logic               r_a_judged, r_b_judged;
  logic               r_a_hit, r_a_miss, r_b_hit, r_b_miss;
  logic [SCORE_W-1:0] r_a_score, r_b_score;
  logic               r_song_done;

  logic [3:0] w_a_edge, w_b_edge;
  logic       w_run_spawn, w_run_wait, w_window_open, w_window_close, w_beat_end;
  logic       w_last_note, w_lfsr_fb;
  logic       w_a_judge, w_b_judge, w_a_close, w_b_close;

  // prev registers track the pads every cycle, even while frozen, so a press
  // made during a pause has already been consumed when play resumes.
  assign w_a_edge       = a_in & ~r_a_prev;
  assign w_b_edge       = b_in & ~r_b_prev;
  assign w_run_spawn    = (r_state == S_SPAWN) && game_active;
  assign w_run_wait     = (r_state == S_WAIT) && game_active;
  assign w_window_open  = r_cnt < WIN_END;
  assign w_window_close = r_cnt == WIN_END;
  assign w_beat_end     = r_cnt == BEAT_END;
  assign w_last_note    = r_note_idx == LAST_IDX;
  assign w_lfsr_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // A player is judged at most once per prompt: first edge inside the window,
  // or a forced miss on the cycle the window closes.
  assign w_a_judge = w_run_wait && w_window_open && !r_a_judged && (w_a_edge != 4'b0);
  assign w_b_judge = w_run_wait && w_window_open && !r_b_judged && (w_b_edge != 4'b0);
  assign w_a_close = w_run_wait && w_window_close && !r_a_judged;
  assign w_b_close = w_run_wait && w_window_close && !r_b_judged;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (game_active) w_state_next = S_SPAWN;
      S_SPAWN: if (game_active) w_state_next = S_WAIT;
      // SPAWN (1) + WAIT counts 0..BEAT-2 (BEAT-1) gives a BEAT-cycle period.
      S_WAIT:  if (game_active && w_beat_end) w_state_next = w_last_note ? S_DONE : S_SPAWN;
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr       <= SEED;
      r_cnt        <= '0;
      r_note_dir   <= 4'b0;
      r_note_valid <= 1'b0;
      r_note_idx   <= 8'd0;
      r_a_prev     <= 4'b0;
      r_b_prev     <= 4'b0;
      r_a_judged   <= 1'b0;
      r_b_judged   <= 1'b0;
      r_a_hit      <= 1'b0;
      r_a_miss     <= 1'b0;
      r_b_hit      <= 1'b0;
      r_b_miss     <= 1'b0;
      r_a_score    <= '0;
      r_b_score    <= '0;
      r_song_done  <= 1'b0;
    end else begin
      r_a_prev <= a_in;
      r_b_prev <= b_in;
      r_a_hit  <= 1'b0;
      r_a_miss <= 1'b0;
      r_b_hit  <= 1'b0;
      r_b_miss <= 1'b0;

      if (w_run_spawn) begin
        r_note_dir   <= 4'b0001 << r_lfsr[1:0];
        r_lfsr       <= {r_lfsr[6:0], w_lfsr_fb};
        r_note_idx   <= r_note_idx + 8'd1;
        r_cnt        <= '0;
        r_note_valid <= (WIN_END != '0);
        r_a_judged   <= 1'b0;
        r_b_judged   <= 1'b0;
      end

      if (w_run_wait) begin
        r_cnt        <= r_cnt + CNT_ONE;
        // Registered view of "count < window" for the count about to be held.
        r_note_valid <= (r_cnt + CNT_ONE) < WIN_END;
        if (w_beat_end && w_last_note) begin
          r_note_dir   <= 4'b0;
          r_note_valid <= 1'b0;
          r_song_done  <= 1'b1;
        end

        if (w_a_judge) begin
          r_a_judged <= 1'b1;
          if (w_a_edge == r_note_dir) begin
            r_a_hit <= 1'b1;
            if (r_a_score != SCORE_MAX) r_a_score <= r_a_score + SCORE_ONE;
          end else begin
            r_a_miss <= 1'b1;
          end
        end else if (w_a_close) begin
          r_a_judged <= 1'b1;
          r_a_miss   <= 1'b1;
        end

        if (w_b_judge) begin
          r_b_judged <= 1'b1;
          if (w_b_edge == r_note_dir) begin
            r_b_hit <= 1'b1;
            if (r_b_score != SCORE_MAX) r_b_score <= r_b_score + SCORE_ONE;
          end else begin
            r_b_miss <= 1'b1;
          end
        end else if (w_b_close) begin
          r_b_judged <= 1'b1;
          r_b_miss   <= 1'b1;
        end
      end
    end
  end

  assign note_dir   = r_note_dir;
  assign note_valid = r_note_valid;
  assign note_idx   = r_note_idx;
  assign a_hit      = r_a_hit;
  assign a_miss     = r_a_miss;
  assign b_hit      = r_b_hit;
  assign b_miss     = r_b_miss;
  assign a_score    = r_a_score;
  assign b_score    = r_b_score;
  assign song_done  = r_song_done;
  assign state_dbg  = r_state;

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences gameplay for the two-player dance game.
- Spawns one arrow prompt per beat from an internal LFSR pattern and opens a hit window for each prompt.
- Judges the debounced player A and player B pad inputs against the prompt and keeps a per-player score.
- Sits between the game controller (which supplies game_active) and the input-processing block (which supplies the cleaned a_out/b_out); drives the display, audio and score logic.

Parameters:
- BEAT_CYCLES, 25_000_000: clock cycles from one prompt spawn to the next while running.
- WINDOW_CYCLES, 5_000_000: cycles after spawn during which the prompt is hittable. Must be ≤ BEAT_CYCLES-2.
- NUM_NOTES, 32: prompts per song, range 1..255.
- SEED, 8'h01: LFSR reset value. Must be nonzero.
- SCORE_W, 16: score counter width.

Ports:
- clock, input, 1: system clock (50 MHz).
- reset, input, 1: synchronous, active-high; clears all state on the next clock edge.
- game_active, input, 1: level; 1 = run, 0 = freeze (pause or not started).
- a_in, input, 4: player A debounced pads, one-hot per direction: [0] up, [1] down, [2] left, [3] right.
- b_in, input, 4: player B debounced pads, same encoding as a_in.
- note_dir, output, 4: one-hot direction of the current prompt; 0 when no prompt.
- note_valid, output, 1: hit window open.
- note_idx, output, 8: number of prompts spawned so far.
- a_hit, a_miss, b_hit, b_miss, output, 1 each: single-cycle judgement pulses.
- a_score, b_score, output, SCORE_W each: hit counts.
- song_done, output, 1: all prompts finished.

Behaviour:
- Reset values: every output 0; state IDLE; LFSR = SEED; beat counter 0; prev-input registers 0; judged flags 0.
- Edge detection
  - a_prev/b_prev register a_in/b_in every cycle, including while frozen.
  - Rising edges: a_edge = a_in & ~a_prev (same for B).
  - A press held through a pause is therefore never counted after resume.
- States
  - IDLE: outputs held at reset values. Go to SPAWN when game_active=1.
  - SPAWN (1 cycle):
    - note_dir <= onehot(lfsr[1:0]) (0→0001, 1→0010, 2→0100, 3→1000).
    - LFSR shifts left; new bit0 = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
    - note_idx increments; beat counter <= 0; judged flags cleared.
    - Go to WAIT.
  - WAIT:
    - The beat counter increments on each cycle with game_active=1.
    - note_valid = 1 while the counter < WINDOW_CYCLES (registered, so it rises the cycle after SPAWN).
    - When the counter reaches BEAT_CYCLES-2 while running: go to DONE if note_idx == NUM_NOTES, else go to SPAWN.
    - Spawn-to-spawn period is exactly BEAT_CYCLES running cycles.
  - DONE: song_done = 1, note_dir = 0, note_valid = 0. Held until reset; game_active is ignored.
- Freeze
  - game_active=0 in SPAWN or WAIT: state, beat counter, LFSR and note_dir all hold.
  - No judgements are made and edges are ignored.
  - note_valid holds its value but has no effect.
- Judging (per player, independent, same cycle allowed)
  - Applies only in WAIT, running, window open, player not yet judged, and edge ≠ 0.
  - Hit: edge == note_dir exactly → hit pulse; score += 1, saturating at all-ones.
  - Otherwise (wrong pad, or extra pads pressed): miss pulse.
  - Either outcome sets the player's judged flag.
- Window close: on the cycle the counter reaches WINDOW_CYCLES, each unjudged player gets one miss pulse. That is exactly one hit or miss per player per prompt.
- Edges outside the window are ignored with no pulse.
- Reset mid-song: all state returns to reset values on the next edge; in-flight pulses are dropped.

Test Plan (BEAT_CYCLES=20, WINDOW_CYCLES=8, NUM_NOTES=4, SEED=8'h01):
1. Reset, then game_active=1.
   - Expect SPAWN → note_dir=0010, note_idx=1.
   - Second prompt 20 cycles later with note_dir=0100, note_idx=2.
2. Player A presses a_in=0010 three cycles into prompt 1.
   - Expect a_hit for one cycle and a_score=1.
   - Expect b_miss at window close and b_score=0.
3. Player B presses 0001 then 0010 inside the same window.
   - Expect exactly one b_miss, no b_hit, b_score unchanged.
4. game_active=0 for 50 cycles mid-window while A holds the correct pad; release, then resume.
   - Expect no pulses, counter and note_dir frozen.
   - Window completes after resume with a_miss (the held edge was consumed during the pause).
5. Both players hit the correct pad on prompts 1–4.
   - Expect a_score=b_score=4.
   - Expect song_done=1 20 cycles after the 4th spawn; note_dir=0; state stays in DONE with game_active toggling.
6. Assert reset during prompt 3.
   - Next cycle: scores, note_idx and song_done are 0, and the LFSR is back to 8'h01 (first prompt direction 0010 again).
